// File: rtl/aes_shift_rows_stage.sv
// rtl/aes_shift_rows_stage.sv - registered ShiftRows/InvShiftRows stage with two-entry skid buffer
// Row rotation is applied before storage so both entries already hold shifted state.
module aes_shift_rows_stage #(
  parameter int ROUND_W        = 4,
  parameter int LAST_ROUND     = 10,
  parameter int CNT_W          = 16,
  parameter int AES_BLOCK_SIZE = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_enc,
  input  logic [ROUND_W-1:0]        in_round,
  input  logic [AES_BLOCK_SIZE-1:0] in_block,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_enc,
  output logic [ROUND_W-1:0]        out_round,
  output logic                      out_last,
  output logic [AES_BLOCK_SIZE-1:0] out_block,
  output logic [CNT_W-1:0]          out_count
);

  // Byte k sits at row k%4, column k/4; each row r rotates by r columns.
  function automatic logic [AES_BLOCK_SIZE-1:0] shift_rows(
    input logic [AES_BLOCK_SIZE-1:0] blk,
    input logic                      enc
  );
    logic [AES_BLOCK_SIZE-1:0] res;
    int src_c;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src_c = enc ? ((c + r) % 4) : ((c - r + 4) % 4);
        res[8*(r+4*c) +: 8] = blk[8*(r+4*src_c) +: 8];
      end
    end
    return res;
  endfunction

  logic                      main_valid;
  logic                      main_enc;
  logic [ROUND_W-1:0]        main_round;
  logic                      main_last;
  logic [AES_BLOCK_SIZE-1:0] main_block;

  logic                      skid_valid;
  logic                      skid_enc;
  logic [ROUND_W-1:0]        skid_round;
  logic                      skid_last;
  logic [AES_BLOCK_SIZE-1:0] skid_block;

  logic [CNT_W-1:0]          count;

  logic                      acc;
  logic                      drn;
  logic [AES_BLOCK_SIZE-1:0] shifted;
  logic                      in_last;

  assign in_ready = ~skid_valid;
  assign acc      = in_valid & in_ready;
  assign drn      = main_valid & out_ready;
  assign shifted  = shift_rows(in_block, in_enc);
  assign in_last  = (in_round == ROUND_W'(LAST_ROUND));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_enc   <= 1'b0;
      main_round <= '0;
      main_last  <= 1'b0;
      main_block <= '0;
      skid_valid <= 1'b0;
      skid_enc   <= 1'b0;
      skid_round <= '0;
      skid_last  <= 1'b0;
      skid_block <= '0;
    end else if (!main_valid || drn) begin
      // main is free this cycle; skid has priority to keep order
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_enc   <= skid_enc;
        main_round <= skid_round;
        main_last  <= skid_last;
        main_block <= skid_block;
        skid_valid <= 1'b0;
      end else if (acc) begin
        main_valid <= 1'b1;
        main_enc   <= in_enc;
        main_round <= in_round;
        main_last  <= in_last;
        main_block <= shifted;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_enc   <= in_enc;
      skid_round <= in_round;
      skid_last  <= in_last;
      skid_block <= shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (drn) begin
      count <= count + 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_enc   = main_enc;
  assign out_round = main_round;
  assign out_last  = main_last;
  assign out_block = main_block;
  assign out_count = count;

endmodule

// File: tb/tb_aes_shift_rows_stage.sv
// tb/tb_aes_shift_rows_stage.sv - directed and scoreboard bench for aes_shift_rows_stage
module tb_aes_shift_rows_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_enc;
  logic [3:0]   in_round;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_enc;
  logic [3:0]   out_round;
  logic         out_last;
  logic [127:0] out_block;
  logic [15:0]  out_count;

  logic         in_ready4;
  logic         out_valid4;
  logic         out_enc4;
  logic [3:0]   out_round4;
  logic         out_last4;
  logic [127:0] out_block4;
  logic [3:0]   out_count4;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] VEC_IN  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] VEC_ENC = 128'he598271ef11141b8ae52b4e0305dbfd4;

  int enc_src [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  int dec_src [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  aes_shift_rows_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_enc(in_enc),
    .in_round(in_round), .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_enc(out_enc), .out_round(out_round), .out_last(out_last), .out_block(out_block),
    .out_count(out_count)
  );

  aes_shift_rows_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_enc(in_enc),
    .in_round(in_round), .in_block(in_block), .out_valid(out_valid4), .out_ready(out_ready),
    .out_enc(out_enc4), .out_round(out_round4), .out_last(out_last4), .out_block(out_block4),
    .out_count(out_count4)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model(input logic [127:0] b, input logic enc);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = enc ? b[8*enc_src[k] +: 8] : b[8*dec_src[k] +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_enc = 1'b0;
    in_round = '0;
    in_block = '0;
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_block !== '0 || out_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b block=%h count=%0d, required 0/0/0", out_valid, out_block, out_count);
    end
    checks++;
    if (in_ready !== 1'b1 || out_enc !== 1'b0 || out_round !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_tags: in_ready=%b enc=%b round=%0d last=%b, required 1/0/0/0", in_ready, out_enc, out_round, out_last);
    end
  endtask

  task automatic test_encrypt_vector();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_enc = 1'b1;
    in_round = 4'd1;
    in_block = VEC_IN;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_block !== VEC_ENC || out_enc !== 1'b1) begin
      failures++;
      $display("FAIL encrypt_vector: valid=%b enc=%b block=%h, required 1/1/%h", out_valid, out_enc, out_block, VEC_ENC);
    end
    step();
  endtask

  task automatic test_decrypt_vector();
    in_valid = 1'b1;
    in_enc = 1'b0;
    in_round = 4'd2;
    in_block = VEC_ENC;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_block !== VEC_IN || out_enc !== 1'b0) begin
      failures++;
      $display("FAIL decrypt_vector: valid=%b enc=%b block=%h, required 1/0/%h", out_valid, out_enc, out_block, VEC_IN);
    end
    step();
  endtask

  task automatic test_roundtrip();
    logic [127:0] orig;
    logic [127:0] mid;
    int bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      orig = rand_block();
      in_valid = 1'b1;
      in_enc = 1'b1;
      in_block = orig;
      step();
      mid = out_block;
      if (mid !== model(orig, 1'b1)) bad++;
      in_enc = 1'b0;
      in_block = mid;
      step();
      if (out_block !== orig) bad++;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL roundtrip: %0d mismatching blocks, required 0", bad);
    end
  endtask

  task automatic test_stream();
    logic [127:0] blks [8];
    int bad_ready = 0;
    int bad_data = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      blks[i] = rand_block();
      in_valid = 1'b1;
      in_enc = i[0];
      in_round = 4'(i + 3);
      in_block = blks[i];
      if (in_ready !== 1'b1) bad_ready++;
      step();
      if (out_valid !== 1'b1 || out_block !== model(blks[i], i[0]) || out_round !== 4'(i + 3)
          || out_last !== (i == 7)) bad_data++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL stream_in_ready: %0d cycles low, required 0", bad_ready);
    end
    checks++;
    if (bad_data != 0) begin
      failures++;
      $display("FAIL stream_data: %0d bad outputs, required 0", bad_data);
    end
    step();
    checks++;
    if (out_count !== 16'd8 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_count: count=%0d valid=%b, required 8/0", out_count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, c;
    a = rand_block();
    b = rand_block();
    c = rand_block();
    do_reset();
    in_enc = 1'b1;
    in_round = 4'd5;
    in_valid = 1'b1;
    in_block = a;
    step();
    in_block = b;
    step();
    checks++;
    if (in_ready !== 1'b0 || out_block !== model(a, 1'b1)) begin
      failures++;
      $display("FAIL bp_after_b: in_ready=%b block=%h, required 0/%h", in_ready, out_block, model(a, 1'b1));
    end
    in_block = c;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_block !== model(a, 1'b1) || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold_a: valid=%b in_ready=%b block=%h, required 1/0/%h", out_valid, in_ready, out_block, model(a, 1'b1));
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_block !== model(b, 1'b1) || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_emit_b: in_ready=%b block=%h, required 1/%h", in_ready, out_block, model(b, 1'b1));
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_block !== model(c, 1'b1)) begin
      failures++;
      $display("FAIL bp_emit_c: valid=%b block=%h, required 1/%h", out_valid, out_block, model(c, 1'b1));
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd3) begin
      failures++;
      $display("FAIL bp_done: valid=%b count=%0d, required 0/3", out_valid, out_count);
    end
  endtask

  task automatic test_random();
    logic [127:0] q_blk [$];
    logic         q_enc [$];
    logic [3:0]   q_rnd [$];
    int sent = 0;
    int hs = 0;
    int cyc = 0;
    int bad = 0;
    int bad_hold = 0;
    int bad_cnt = 0;
    int bad_flow = 0;
    logic         held;
    logic [127:0] held_blk;
    logic         acc, drn;
    do_reset();
    held = 1'b0;
    held_blk = '0;
    while ((sent < 1000 || q_blk.size() != 0) && cyc < 20000) begin
      in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_block = rand_block();
      in_enc = 1'($urandom_range(0, 1));
      in_round = 4'($urandom_range(0, 15));
      out_ready = (sent >= 1000) || ($urandom_range(0, 1) == 1);
      if (in_ready !== (q_blk.size() < 2) || in_ready4 !== (q_blk.size() < 2)) bad_flow++;
      if (out_valid !== (q_blk.size() > 0) || out_valid4 !== (q_blk.size() > 0)) bad_flow++;
      if (held && out_block !== held_blk) bad_hold++;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        if (out_block !== q_blk[0] || out_enc !== q_enc[0] || out_round !== q_rnd[0]
            || out_last !== (q_rnd[0] == 4'd10)) bad++;
        if (out_block4 !== q_blk[0] || out_enc4 !== q_enc[0] || out_round4 !== q_rnd[0]
            || out_last4 !== (q_rnd[0] == 4'd10)) bad++;
        void'(q_blk.pop_front());
        void'(q_enc.pop_front());
        void'(q_rnd.pop_front());
        hs++;
      end
      if (acc) begin
        q_blk.push_back(model(in_block, in_enc));
        q_enc.push_back(in_enc);
        q_rnd.push_back(in_round);
        sent++;
      end
      held = out_valid && !out_ready;
      held_blk = out_block;
      step();
      cyc++;
      if (out_count !== 16'(hs) || out_count4 !== 4'(hs)) bad_cnt++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL random_timeout: %0d cycles, %0d blocks outstanding", cyc, q_blk.size());
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL random_data: %0d bad handshakes, required 0", bad);
    end
    checks++;
    if (bad_hold != 0 || bad_flow != 0) begin
      failures++;
      $display("FAIL random_flow: hold_errs=%0d flow_errs=%0d, required 0/0", bad_hold, bad_flow);
    end
    checks++;
    if (bad_cnt != 0 || hs != 1000 || hs < 16) begin
      failures++;
      $display("FAIL random_count: count_errs=%0d handshakes=%0d, required 0/1000", bad_cnt, hs);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_enc = 1'b1;
    in_round = 4'd10;
    in_block = rand_block();
    step();
    step();
    out_ready = 1'b0;
    step();
    in_block = rand_block();
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_block !== '0 || out_count !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: valid=%b block=%h count=%0d in_ready=%b, required 0/0/0/1", out_valid, out_block, out_count, in_ready);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid !== 1'b0 || out_count !== '0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL reset_stale: %0d cycles with output activity, required 0", stale);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_encrypt_vector();
    test_decrypt_vector();
    test_roundtrip();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
